// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM states, debug response codes and
// the slave-index width helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_SLVERR  = 2'd1,
    RSP_DECERR  = 2'd2,
    RSP_TIMEOUT = 2'd3
  } apb_rsp_e;

  function automatic int sel_width(input int num_slaves);
    return (num_slaves <= 1) ? 1 : $clog2(num_slaves);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decoder: slave index taken from addr[SLV_LSB +: SEL_W],
// one-hot select, and a flag for indices with no slave behind them.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SLV_LSB    = 12,
  parameter int SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [SEL_W-1:0]      o_index,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic                  o_decode_err
);

  logic w_unused_addr;
  assign w_unused_addr = ^i_addr;

  always_comb begin
    o_index = i_addr[SLV_LSB +: SEL_W];
    o_sel   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (o_index == SEL_W'(i)) o_sel[i] = 1'b1;
    end
    o_decode_err = ({1'b0, o_index} >= (SEL_W + 1)'(NUM_SLAVES));
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-beat valid/ready to APB master bridge with address decode to NUM_SLAVES.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  // Request: accepted at an edge where req_valid && req_ready; fields must be
  // held while req_valid=1 and req_ready=0. Response is a one-cycle rsp_valid.
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic                           req_write,
  input  logic [DATA_W-1:0]              req_wdata,
  input  logic [DATA_W/8-1:0]            req_strb,
  output logic                           rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           rsp_err,
  output logic [NUM_SLAVES-1:0]          PSEL,
  output logic                           PENABLE,
  output logic [ADDR_W-1:0]              PADDR,
  output logic                           PWRITE,
  output logic [DATA_W-1:0]              PWDATA,
  output logic [DATA_W/8-1:0]            PSTRB,
  input  logic [NUM_SLAVES*DATA_W-1:0]   PRDATA,
  input  logic [NUM_SLAVES-1:0]          PREADY,
  input  logic [NUM_SLAVES-1:0]          PSLVERR,
  output apb_state_e                     o_dbg_state,
  output apb_rsp_e                       o_dbg_rsp_code
);

  localparam int SEL_W  = sel_width(NUM_SLAVES);
  localparam int STRB_W = DATA_W / 8;

  apb_state_e              r_state, w_state_nxt;
  logic                    r_req_ready, w_req_ready_nxt;
  logic [NUM_SLAVES-1:0]   r_psel, w_psel_nxt;
  logic                    r_penable, w_penable_nxt;
  logic [ADDR_W-1:0]       r_paddr, w_paddr_nxt;
  logic                    r_pwrite, w_pwrite_nxt;
  logic [DATA_W-1:0]       r_pwdata, w_pwdata_nxt;
  logic [STRB_W-1:0]       r_pstrb, w_pstrb_nxt;
  logic [SEL_W-1:0]        r_idx, w_idx_nxt;
  logic                    r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]       r_rsp_rdata, w_rsp_rdata_nxt;
  logic                    r_rsp_err, w_rsp_err_nxt;
  apb_rsp_e                r_rsp_code, w_rsp_code_nxt;

  logic [SEL_W-1:0]        w_dec_idx;
  logic [NUM_SLAVES-1:0]   w_dec_sel;
  logic                    w_dec_err;
  logic                    w_pready_sel;
  logic                    w_pslverr_sel;
  logic [DATA_W-1:0]       w_prdata_sel;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        r_wait_cnt, w_wait_cnt_nxt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  apb_addr_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_SLAVES(NUM_SLAVES),
    .SLV_LSB   (SLV_LSB),
    .SEL_W     (SEL_W)
  ) u_decode (
    .i_addr      (req_addr),
    .o_index     (w_dec_idx),
    .o_sel       (w_dec_sel),
    .o_decode_err(w_dec_err)
  );

  // Only the latched slave's PREADY/PSLVERR/PRDATA are ever looked at.
  always_comb begin
    w_pready_sel  = 1'b0;
    w_pslverr_sel = 1'b0;
    w_prdata_sel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx == SEL_W'(i)) begin
        w_pready_sel  = PREADY[i];
        w_pslverr_sel = PSLVERR[i];
        w_prdata_sel  = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = r_req_ready;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_paddr_nxt     = r_paddr;
    w_pwrite_nxt    = r_pwrite;
    w_pwdata_nxt    = r_pwdata;
    w_pstrb_nxt     = r_pstrb;
    w_idx_nxt       = r_idx;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_code_nxt  = r_rsp_code;
`ifdef APB_TIMEOUT_EN
    w_wait_cnt_nxt  = r_wait_cnt;
`endif
    case (r_state)
      IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (req_valid && r_req_ready) begin
          w_req_ready_nxt = 1'b0;
          if (w_dec_err) begin
            w_state_nxt = DERR;
          end else begin
            w_state_nxt   = SETUP;
            w_psel_nxt    = w_dec_sel;
            w_penable_nxt = 1'b0;
            w_paddr_nxt   = req_addr;
            w_pwrite_nxt  = req_write;
            w_pwdata_nxt  = req_wdata;
            w_pstrb_nxt   = req_write ? req_strb : '0;
            w_idx_nxt     = w_dec_idx;
          end
        end
      end
      SETUP: begin
        w_state_nxt   = ACCESS;
        w_penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
        w_wait_cnt_nxt = '0;
`endif
      end
      ACCESS: begin
        // PREADY is checked first so it wins over a coincident terminal count.
        if (w_pready_sel) begin
          w_state_nxt     = IDLE;
          w_req_ready_nxt = 1'b1;
          w_psel_nxt      = '0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_pwrite ? '0 : w_prdata_sel;
          w_rsp_err_nxt   = w_pslverr_sel;
          w_rsp_code_nxt  = w_pslverr_sel ? RSP_SLVERR : RSP_OK;
`ifdef APB_TIMEOUT_EN
        end else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt     = IDLE;
          w_req_ready_nxt = 1'b1;
          w_psel_nxt      = '0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_code_nxt  = RSP_TIMEOUT;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
`endif
        end
      end
      DERR: begin
        w_state_nxt     = IDLE;
        w_req_ready_nxt = 1'b1;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = 1'b1;
        w_rsp_code_nxt  = RSP_DECERR;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_code  <= RSP_OK;
`ifdef APB_TIMEOUT_EN
      r_wait_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_pstrb     <= w_pstrb_nxt;
      r_idx       <= w_idx_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_code  <= w_rsp_code_nxt;
`ifdef APB_TIMEOUT_EN
      r_wait_cnt  <= w_wait_cnt_nxt;
`endif
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_err        = r_rsp_err;
  assign PSEL           = r_psel;
  assign PENABLE        = r_penable;
  assign PADDR          = r_paddr;
  assign PWRITE         = r_pwrite;
  assign PWDATA         = r_pwdata;
  assign PSTRB          = r_pstrb;
  assign o_dbg_state    = r_state;
  assign o_dbg_rsp_code = r_rsp_code;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a 4-slave instance driven from a vector
// table plus hand sequences, and a 3-slave instance for decode errors.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic         req_valid, req_valid1;
  logic [31:0]  req_addr;
  logic         req_write;
  logic [31:0]  req_wdata;
  logic [3:0]   req_strb;

  logic         req_ready, rsp_valid, rsp_err, PENABLE, PWRITE;
  logic [31:0]  rsp_rdata, PADDR, PWDATA;
  logic [3:0]   PSEL, PSTRB, PREADY, PSLVERR;
  logic [127:0] PRDATA;
  apb_state_e   dbg_state;
  apb_rsp_e     dbg_code;

  logic         req_ready1, rsp_valid1, rsp_err1, PENABLE1, PWRITE1;
  logic [31:0]  rsp_rdata1, PADDR1, PWDATA1;
  logic [2:0]   PSEL1;
  logic [3:0]   PSTRB1;
  logic [95:0]  PRDATA1;
  apb_state_e   dbg_state1;
  apb_rsp_e     dbg_code1;

  int checks = 0;
  int failures = 0;

  // slave model controls
  logic        s_active = 1'b0;
  int          s_idx = 0;
  int          s_waits = 0;
  logic        s_err = 1'b0;
  logic        s_err_pulse = 1'b0;
  int          s_acc = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.NUM_SLAVES(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .o_dbg_state(dbg_state), .o_dbg_rsp_code(dbg_code)
  );

  apb_master_bridge #(.NUM_SLAVES(3)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .PSEL(PSEL1), .PENABLE(PENABLE1), .PADDR(PADDR1), .PWRITE(PWRITE1),
    .PWDATA(PWDATA1), .PSTRB(PSTRB1), .PRDATA(PRDATA1), .PREADY(3'b111),
    .PSLVERR(3'b000), .o_dbg_state(dbg_state1), .o_dbg_rsp_code(dbg_code1)
  );

  // Slave model: unselected slaves always claim ready+error so that any leak
  // shows; the selected slave answers after s_waits ACCESS cycles.
  always @(negedge PCLK) begin
    logic [3:0] rdy_v, err_v;
    if (s_active) begin
      rdy_v = 4'hF;
      err_v = 4'hF;
      if (PSEL[s_idx] && PENABLE) s_acc = s_acc + 1;
      else s_acc = 0;
      rdy_v[s_idx] = (s_acc > s_waits);
      err_v[s_idx] = (s_acc > s_waits) ? s_err : (s_err_pulse && s_acc == 1);
    end else begin
      s_acc = 0;
      rdy_v = 4'hF;
      err_v = 4'h0;
    end
    PREADY  = rdy_v;
    PSLVERR = err_v;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slverr;
    logic        err_pulse;
    logic [31:0] sdata;
    logic [3:0]  exp_psel;
    logic [31:0] exp_rdata;
    logic        chk_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int waits, input logic slverr,
                              input logic pulse, input logic [31:0] sdata, input logic [3:0] psel,
                              input logic [31:0] rdata, input logic chk, input logic err,
                              input int lat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.waits = waits;
    v.slverr = slverr; v.err_pulse = pulse; v.sdata = sdata; v.exp_psel = psel;
    v.exp_rdata = rdata; v.chk_rdata = chk; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge PCLK);
      k++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic        seen = 1'b0;
    logic        stable = 1'b1;
    int          lat = 0;
    logic [3:0]  psel_r = 4'hx;
    logic        pen_r = 1'bx;
    logic        rdy_r = 1'bx;
    logic        err_r = 1'bx;
    logic [31:0] rdata_r = 32'hx;
    logic [3:0]  s_psel = 4'h0;
    logic [31:0] s_addr = 32'h0, s_wdata = 32'h0;
    logic [3:0]  s_strb = 4'h0;
    s_idx = int'(v.addr[13:12]);
    for (int i = 0; i < 4; i++) PRDATA[i*32 +: 32] = 32'hBAD0_0000 | i;
    PRDATA[s_idx*32 +: 32] = v.sdata;
    s_waits = v.waits; s_err = v.slverr; s_err_pulse = v.err_pulse; s_active = 1'b1;
    @(negedge PCLK);
    wait_ready();
    check($sformatf("v%0d_ready", n), req_ready, 1'b1);
    req_addr = v.addr; req_write = v.wr; req_wdata = v.wdata; req_strb = v.strb;
    req_valid = 1'b1;
    @(posedge PCLK);
    #1 req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge PCLK);
      if (cyc == 1) begin
        check($sformatf("v%0d_setup_psel", n), PSEL, v.exp_psel);
        check($sformatf("v%0d_setup_penable", n), PENABLE, 1'b0);
        check($sformatf("v%0d_paddr", n), PADDR, v.addr);
        check($sformatf("v%0d_pwrite", n), PWRITE, v.wr);
        check($sformatf("v%0d_pstrb", n), PSTRB, v.wr ? v.strb : 4'h0);
        if (v.wr) check($sformatf("v%0d_pwdata", n), PWDATA, v.wdata);
        s_psel = PSEL; s_addr = PADDR; s_wdata = PWDATA; s_strb = PSTRB;
      end
      if (cyc == 2) begin
        check($sformatf("v%0d_access_penable", n), PENABLE, 1'b1);
        check($sformatf("v%0d_access_state", n), 32'(dbg_state), 32'(ACCESS));
      end
      if (cyc >= 2 && !rsp_valid) begin
        if (PSEL !== s_psel || PADDR !== s_addr || PWDATA !== s_wdata ||
            PSTRB !== s_strb || PWRITE !== v.wr || PENABLE !== 1'b1) stable = 1'b0;
      end
      if (rsp_valid === 1'b1) begin
        seen = 1'b1; lat = cyc;
        psel_r = PSEL; pen_r = PENABLE; rdy_r = req_ready;
        err_r = rsp_err; rdata_r = rsp_rdata;
      end
    end
    s_active = 1'b0;
    check($sformatf("v%0d_rsp_seen", n), seen, 1'b1);
    check($sformatf("v%0d_latency", n), lat, v.exp_lat);
    check($sformatf("v%0d_stable", n), stable, 1'b1);
    check($sformatf("v%0d_rsp_err", n), err_r, v.exp_err);
    if (v.chk_rdata) check($sformatf("v%0d_rsp_rdata", n), rdata_r, v.exp_rdata);
    check($sformatf("v%0d_rsp_psel", n), {psel_r, pen_r}, 5'b0);
    check($sformatf("v%0d_rsp_ready", n), rdy_r, 1'b1);
  endtask

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    PRESETn = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0;
    req_addr = '0; req_write = 1'b0; req_wdata = '0; req_strb = '0;
    PRDATA = '0;
    PRDATA1 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};

    vecs[0] = mk(1, 32'h1004, 32'h0000_ABCD, 4'hF, 0, 0, 0, 32'h0,         4'b0010, 32'h0,         1, 0, 3);
    vecs[1] = mk(0, 32'h1004, 32'h0,         4'hF, 3, 0, 0, 32'h0000_ABCD, 4'b0010, 32'h0000_ABCD, 1, 0, 6);
    vecs[2] = mk(0, 32'h3000, 32'h0,         4'h0, 1, 1, 0, 32'h5A5A_0003, 4'b1000, 32'h0,         0, 1, 4);
    vecs[3] = mk(0, 32'h2008, 32'h0,         4'h0, 2, 0, 1, 32'h1234_5678, 4'b0100, 32'h1234_5678, 1, 0, 5);
    vecs[4] = mk(1, 32'h0010, 32'hCAFE_F00D, 4'h3, 0, 0, 0, 32'h0,         4'b0001, 32'h0,         1, 0, 3);
    vecs[5] = mk(1, 32'h3FFC, 32'h1122_3344, 4'h8, 1, 1, 0, 32'hFFFF_FFFF, 4'b1000, 32'h0,         1, 1, 4);
    vecs[6] = mk(0, 32'h0000, 32'h0,         4'h0, 0, 0, 0, 32'hDEAD_BEEF, 4'b0001, 32'hDEAD_BEEF, 1, 0, 3);
    vecs[7] = mk(0, 32'h1100, 32'h0,         4'h0, 15, 0, 0, 32'h0F0F_0F0F, 4'b0010, 32'h0F0F_0F0F, 1, 0, 18);
`ifdef APB_TIMEOUT_EN
    vecs[8] = mk(0, 32'h2000, 32'h0,         4'h0, 20, 0, 0, 32'h7777_7777, 4'b0100, 32'h0,         1, 1, 18);
`else
    vecs[8] = mk(0, 32'h2000, 32'h0,         4'h0, 20, 0, 0, 32'h7777_7777, 4'b0100, 32'h7777_7777, 1, 0, 23);
`endif
    vecs[9] = mk(1, 32'h5000, 32'h0000_0055, 4'h1, 0, 0, 0, 32'h0,         4'b0010, 32'h0,         1, 0, 3);

    // reset state
    repeat (3) @(negedge PCLK);
    check("rst_outputs", {req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE, PSTRB}, 32'h0);
    check("rst_data", PADDR | PWDATA | rsp_rdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_dut3", {req_ready1, rsp_valid1, PSEL1, PENABLE1}, 32'h0);
    PRESETn = 1'b1;
    #1 check("rst_ready_before_edge", req_ready, 1'b0);
    @(negedge PCLK);
    check("rst_ready_first_edge", req_ready, 1'b1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // back-to-back with req_valid held high
    for (int i = 0; i < 4; i++) PRDATA[i*32 +: 32] = 32'h2222_0000 | i;
    @(negedge PCLK);
    wait_ready();
    req_addr = 32'h1000; req_write = 1'b1; req_wdata = 32'h1; req_strb = 4'hF;
    req_valid = 1'b1;
    @(posedge PCLK);
    #1 req_addr = 32'h2000; req_write = 1'b0; req_strb = 4'h0;
    @(negedge PCLK);
    check("b2b_a_setup", {PSEL, PENABLE, req_ready}, 6'b0010_0_0);
    @(negedge PCLK);
    check("b2b_a_access", {PSEL, PENABLE}, 5'b0010_1);
    @(negedge PCLK);
    check("b2b_a_rsp", {rsp_valid, rsp_err, req_ready}, 3'b101);
    @(posedge PCLK);
    #1 req_valid = 1'b0;
    @(negedge PCLK);
    check("b2b_b_setup", {PSEL, PENABLE, PWRITE}, 6'b0100_0_0);
    @(negedge PCLK);
    check("b2b_b_access", {PSEL, PENABLE, rsp_valid}, 6'b0100_1_0);
    @(negedge PCLK);
    check("b2b_b_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("b2b_b_rdata", rsp_rdata, 32'h2222_0002);

    // decode error on the 3-slave instance
    @(negedge PCLK);
    req_addr = 32'h3000; req_write = 1'b0; req_valid1 = 1'b1;
    @(posedge PCLK);
    #1 req_valid1 = 1'b0;
    @(negedge PCLK);
    check("derr_c1", {PSEL1, PENABLE1, rsp_valid1, req_ready1}, 6'b0);
    check("derr_state", 32'(dbg_state1), 32'(DERR));
    @(negedge PCLK);
    check("derr_rsp", {PSEL1, PENABLE1, rsp_valid1, rsp_err1, req_ready1}, 7'b000_0_111);
    check("derr_rdata", rsp_rdata1, 32'h0);
    check("derr_code", 32'(dbg_code1), 32'(RSP_DECERR));
    @(negedge PCLK);
    check("derr_pulse_end", rsp_valid1, 1'b0);

    // legal index on the 3-slave instance
    req_addr = 32'h2000; req_valid1 = 1'b1;
    @(posedge PCLK);
    #1 req_valid1 = 1'b0;
    @(negedge PCLK);
    check("ns3_setup_psel", PSEL1, 3'b100);
    repeat (2) @(negedge PCLK);
    check("ns3_rsp", {rsp_valid1, rsp_err1}, 2'b10);
    check("ns3_rdata", rsp_rdata1, 32'h3333_0002);

    // reset asserted in the middle of ACCESS
    s_idx = 2; s_waits = 1000; s_err = 1'b0; s_err_pulse = 1'b0; s_active = 1'b1;
    @(negedge PCLK);
    wait_ready();
    req_addr = 32'h2000; req_write = 1'b0; req_valid = 1'b1;
    @(posedge PCLK);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    check("mid_rst_in_access", {PSEL, PENABLE}, 5'b0100_1);
    #2 PRESETn = 1'b0;
    #1;
    check("mid_rst_async", {req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE, PSTRB}, 32'h0);
    check("mid_rst_paddr", PADDR, 32'h0);
    repeat (2) @(negedge PCLK);
    s_active = 1'b0;
    PRESETn = 1'b1;
    begin
      int rsp_cnt = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge PCLK);
        if (rsp_valid === 1'b1) rsp_cnt++;
        if (i == 0) check("post_rst_ready", req_ready, 1'b1);
      end
      check("post_rst_no_rsp", rsp_cnt, 0);
      check("post_rst_psel", {PSEL, PENABLE}, 5'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
